// File: rtl/uart_reg_pkg.sv
// rtl/uart_reg_pkg.sv - shared constants and state encodings for the debug UART register receiver
package uart_reg_pkg;

    localparam logic [7:0] FRAME_HDR       = 8'hA5;
    localparam int         PAYLOAD_LEN     = 6;
    localparam int         LED_HOLD_CYCLES = 4000000;

    localparam logic [1:0] BYTE_IDLE  = 2'd0;
    localparam logic [1:0] BYTE_START = 2'd1;
    localparam logic [1:0] BYTE_DATA  = 2'd2;
    localparam logic [1:0] BYTE_STOP  = 2'd3;

    localparam logic [1:0] FRM_HDR = 2'd0;
    localparam logic [1:0] FRM_PAY = 2'd1;
    localparam logic [1:0] FRM_CHK = 2'd2;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: input synchroniser, baud counter and byte FSM
module uart_rx_byte
    import uart_reg_pkg::*;
#(
    parameter int DIV = 347
) (
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_rx_en,
    input  logic       i_uart_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_stb,
    output logic       o_ferr_stb
);

    localparam int             HALF   = DIV / 2;
    localparam int             CW     = $clog2(DIV + 1);
    localparam logic [CW-1:0]  HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0]  DIV_M1  = CW'(DIV - 1);

    logic          sync1_q, sync2_q, prev_q;
    logic          fall;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          stb_q, stb_d;
    logic          ferr_q, ferr_d;

    // a falling edge is a 1 -> 0 step of the synchronised line, so a line stuck low never restarts a byte
    assign fall = prev_q & ~sync2_q;

    // two-flop synchroniser plus an edge-history flop, all idling high
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= i_uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // byte FSM: start bit checked at half a bit, data and stop sampled one bit period apart
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        stb_d   = 1'b0;
        ferr_d  = 1'b0;
        if (!i_rx_en) begin
            state_d = BYTE_IDLE;
            cnt_d   = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                BYTE_IDLE: begin
                    cnt_d = '0;
                    if (fall) state_d = BYTE_START;
                end
                BYTE_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = sync2_q ? BYTE_IDLE : BYTE_DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                BYTE_DATA: begin
                    if (cnt_q == DIV_M1) begin
                        cnt_d   = '0;
                        shift_d = {sync2_q, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = BYTE_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                BYTE_STOP: begin
                    if (cnt_q == DIV_M1) begin
                        cnt_d   = '0;
                        state_d = BYTE_IDLE;
                        stb_d   = sync2_q;
                        ferr_d  = ~sync2_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = BYTE_IDLE;
            endcase
        end
    end

    // byte FSM state and the registered strobes
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            state_q <= BYTE_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            stb_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            stb_q   <= stb_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_byte     = shift_q;
    assign o_byte_stb = stb_q;
    assign o_ferr_stb = ferr_q;

endmodule

// File: rtl/uart_reg_rx.sv
// rtl/uart_reg_rx.sv - debug UART frame decoder into six byte registers; checksum byte enabled by UART_REG_RX_CHECKSUM_EN
module uart_reg_rx
    import uart_reg_pkg::*;
#(
    parameter int CLK_FREQ      = 40000000,
    parameter int BAUD          = 115200,
    parameter int TIMEOUT_BYTES = 2,
    parameter int LED_HOLD      = LED_HOLD_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_res_n,
    input  logic        i_rx_en,
    input  logic        i_uart_rx,
    output logic [7:0]  o_reg_1,
    output logic [7:0]  o_reg_2,
    output logic [7:0]  o_reg_3,
    output logic [7:0]  o_reg_4,
    output logic [7:0]  o_reg_5,
    output logic [7:0]  o_reg_6,
    output logic        o_frame_valid,
    output logic [15:0] o_err_cnt,
    output logic        o_rx_led
);

    localparam int          DIV    = CLK_FREQ / BAUD;
    localparam int          TO_LIM = TIMEOUT_BYTES * 10 * DIV;
    localparam int          TW     = $clog2(TO_LIM + 1);
    localparam int          LW     = $clog2(LED_HOLD + 1);
    localparam logic [2:0]  LAST   = 3'(PAYLOAD_LEN - 1);

    logic [7:0]    rx_byte;
    logic          byte_stb, ferr_stb;
    logic [1:0]    frm_q, frm_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shadow_q [PAYLOAD_LEN];
    logic [7:0]    shadow_d [PAYLOAD_LEN];
    logic [7:0]    regs_q   [PAYLOAD_LEN];
    logic [TW-1:0] gap_q, gap_d;
    logic          timeout, commit, err_evt;
    logic          fv_q;
    logic [15:0]   err_q;
    logic [LW-1:0] led_q;
`ifdef UART_REG_RX_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
    logic          cks_err;
`endif

    uart_rx_byte #(.DIV(DIV)) u_byte (
        .i_clk      (i_clk),
        .i_res_n    (i_res_n),
        .i_rx_en    (i_rx_en),
        .i_uart_rx  (i_uart_rx),
        .o_byte     (rx_byte),
        .o_byte_stb (byte_stb),
        .o_ferr_stb (ferr_stb)
    );

    // frame FSM with inter-byte gap watchdog; aborts never touch the output registers
    always_comb begin
        frm_d    = frm_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        commit   = 1'b0;
`ifdef UART_REG_RX_CHECKSUM_EN
        csum_d   = csum_q;
        cks_err  = 1'b0;
`endif
        if (frm_q == FRM_HDR || byte_stb) gap_d = '0;
        else if (gap_q != TW'(TO_LIM))     gap_d = gap_q + TW'(1);
        else                               gap_d = gap_q;
        timeout = i_rx_en && (frm_q != FRM_HDR) && !byte_stb && (gap_q == TW'(TO_LIM));

        if (!i_rx_en || ferr_stb || timeout) begin
            frm_d = FRM_HDR;
            idx_d = '0;
        end else if (byte_stb) begin
            case (frm_q)
                FRM_HDR: begin
                    if (rx_byte == FRAME_HDR) begin
                        frm_d = FRM_PAY;
                        idx_d = '0;
`ifdef UART_REG_RX_CHECKSUM_EN
                        csum_d = FRAME_HDR;
`endif
                    end
                end
                FRM_PAY: begin
                    shadow_d[idx_q] = rx_byte;
`ifdef UART_REG_RX_CHECKSUM_EN
                    csum_d = csum_q ^ rx_byte;
`endif
                    if (idx_q == LAST) begin
                        idx_d = '0;
`ifdef UART_REG_RX_CHECKSUM_EN
                        frm_d = FRM_CHK;
`else
                        frm_d  = FRM_HDR;
                        commit = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
`ifdef UART_REG_RX_CHECKSUM_EN
                FRM_CHK: begin
                    frm_d   = FRM_HDR;
                    commit  = (rx_byte == csum_q);
                    cks_err = (rx_byte != csum_q);
                end
`endif
                default: frm_d = FRM_HDR;
            endcase
        end

        // a framing error and a timeout in the same cycle are one error event
`ifdef UART_REG_RX_CHECKSUM_EN
        err_evt = ferr_stb | timeout | cks_err;
`else
        err_evt = ferr_stb | timeout;
`endif
    end

    // frame FSM state, payload index, gap counter and shadow buffer
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            frm_q <= FRM_HDR;
            idx_q <= '0;
            gap_q <= '0;
            for (int i = 0; i < PAYLOAD_LEN; i++) shadow_q[i] <= '0;
`ifdef UART_REG_RX_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            frm_q    <= frm_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            shadow_q <= shadow_d;
`ifdef UART_REG_RX_CHECKSUM_EN
            csum_q <= csum_d;
`endif
        end
    end

    // output registers and valid pulse update together on a committed frame
    always_ff @(posedge i_clk) begin
        if (!i_res_n) begin
            for (int i = 0; i < PAYLOAD_LEN; i++) regs_q[i] <= '0;
            fv_q <= 1'b0;
        end else begin
            fv_q <= commit;
            if (commit) regs_q <= shadow_d;
        end
    end

    // saturating error counter
    always_ff @(posedge i_clk) begin
        if (!i_res_n)                         err_q <= '0;
        else if (err_evt && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
    end

    // retriggerable activity LED stretcher
    always_ff @(posedge i_clk) begin
        if (!i_res_n)          led_q <= '0;
        else if (commit)       led_q <= LW'(LED_HOLD);
        else if (led_q != '0)  led_q <= led_q - LW'(1);
    end

    assign o_reg_1       = regs_q[0];
    assign o_reg_2       = regs_q[1];
    assign o_reg_3       = regs_q[2];
    assign o_reg_4       = regs_q[3];
    assign o_reg_5       = regs_q[4];
    assign o_reg_6       = regs_q[5];
    assign o_frame_valid = fv_q;
    assign o_err_cnt     = err_q;
    assign o_rx_led      = (led_q != '0);

endmodule

// File: tb/tb_uart_reg_rx.sv
// tb/tb_uart_reg_rx.sv - directed self-checking bench for uart_reg_rx
module tb_uart_reg_rx;

    localparam int CLK_FREQ = 1152000;
    localparam int BAUD     = 115200;
    localparam int DIV      = 10;
    localparam int HALF     = 5;
    localparam int TOB      = 2;
    localparam int TO_CYC   = TOB * 10 * DIV;
    localparam int LED_HOLD = 40;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        rx_en = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  r1, r2, r3, r4, r5, r6;
    logic        fv;
    logic [15:0] err;
    logic        led;

    uart_reg_rx #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TIMEOUT_BYTES(TOB), .LED_HOLD(LED_HOLD)
    ) dut (
        .i_clk(clk), .i_res_n(res_n), .i_rx_en(rx_en), .i_uart_rx(rx),
        .o_reg_1(r1), .o_reg_2(r2), .o_reg_3(r3), .o_reg_4(r4), .o_reg_5(r5), .o_reg_6(r6),
        .o_frame_valid(fv), .o_err_cnt(err), .o_rx_led(led)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int fv_cnt = 0, stb_cnt = 0, cyc = 0, fv_cyc = 0, led_fall_cyc = 0, led_bad = 0;
    logic led_prev = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (fv) begin fv_cnt = fv_cnt + 1; fv_cyc = cyc; end
        if (dut.byte_stb) stb_cnt = stb_cnt + 1;
        if (led && !led_prev && !fv) led_bad = led_bad + 1;
        if (!led && led_prev) led_fall_cyc = cyc;
        led_prev = led;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0; idle(DIV);
        for (int i = 0; i < 8; i++) begin rx = b[i]; idle(DIV); end
        rx = stop; idle(DIV);
        rx = 1'b1;
        if (!stop) idle(DIV);
    endtask

    task automatic send_frame(input logic [47:0] pay, input logic bad_cks);
        logic [7:0] cs;
        cs = 8'hA5;
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 6; i++) begin
            send_byte(pay[47-8*i -: 8], 1'b1);
            cs = cs ^ pay[47-8*i -: 8];
        end
`ifdef UART_REG_RX_CHECKSUM_EN
        send_byte(bad_cks ? 8'h00 : cs, 1'b1);
`else
        if (bad_cks) cs = 8'h00;
`endif
    endtask

    task automatic do_reset();
        res_n = 1'b0; idle(2); res_n = 1'b1; rx_en = 1'b1; idle(2);
    endtask

    task automatic test_reset();
        res_n = 1'b0; rx_en = 1'b0; rx = 1'b1; idle(3);
        vectors++; if ({r1, r2, r3, r4, r5, r6} !== 48'h0) begin miscompares++; $display("FAIL reset_regs got %h exp 0", {r1, r2, r3, r4, r5, r6}); end
        vectors++; if (fv !== 1'b0) begin miscompares++; $display("FAIL reset_fv got %b exp 0", fv); end
        vectors++; if (err !== 16'h0) begin miscompares++; $display("FAIL reset_err got %h exp 0", err); end
        vectors++; if (led !== 1'b0) begin miscompares++; $display("FAIL reset_led got %b exp 0", led); end
        res_n = 1'b1; rx_en = 1'b1; idle(2);
    endtask

    task automatic test_valid_frame();
        int f0;
        do_reset();
        f0 = fv_cnt;
        send_frame(48'h123456789ABC, 1'b0); idle(2 * DIV);
        vectors++; if (fv_cnt - f0 !== 1) begin miscompares++; $display("FAIL valid_pulses got %0d exp 1", fv_cnt - f0); end
        vectors++; if ({r1, r2, r3, r4, r5, r6} !== 48'h123456789ABC) begin miscompares++; $display("FAIL valid_regs got %h exp 123456789abc", {r1, r2, r3, r4, r5, r6}); end
        vectors++; if (err !== 16'd0) begin miscompares++; $display("FAIL valid_err got %0d exp 0", err); end
        vectors++; if (led !== 1'b1) begin miscompares++; $display("FAIL valid_led_on got %b exp 1", led); end
        idle(LED_HOLD + 5);
        vectors++; if (led_fall_cyc - fv_cyc !== LED_HOLD) begin miscompares++; $display("FAIL led_hold got %0d exp %0d", led_fall_cyc - fv_cyc, LED_HOLD); end
        vectors++; if (led_bad !== 0) begin miscompares++; $display("FAIL led_rise_align got %0d exp 0", led_bad); end
    endtask

`ifdef UART_REG_RX_CHECKSUM_EN
    task automatic test_bad_checksum();
        int f0;
        f0 = fv_cnt;
        send_frame(48'h123456789ABC, 1'b1); idle(2 * DIV);
        vectors++; if (fv_cnt - f0 !== 0) begin miscompares++; $display("FAIL cks_pulses got %0d exp 0", fv_cnt - f0); end
        vectors++; if ({r1, r2, r3, r4, r5, r6} !== 48'h123456789ABC) begin miscompares++; $display("FAIL cks_regs got %h exp 123456789abc", {r1, r2, r3, r4, r5, r6}); end
        vectors++; if (err !== 16'd1) begin miscompares++; $display("FAIL cks_err got %0d exp 1", err); end
    endtask
`endif

    task automatic test_rx_en_abort();
        int f0;
        do_reset();
        f0 = fv_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        rx_en = 1'b0; idle(5); rx_en = 1'b1; idle(2);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1); send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
        idle(2 * DIV);
        vectors++; if (fv_cnt - f0 !== 0) begin miscompares++; $display("FAIL en_abort_pulses got %0d exp 0", fv_cnt - f0); end
        vectors++; if (err !== 16'd0) begin miscompares++; $display("FAIL en_abort_err got %0d exp 0", err); end
        vectors++; if ({r1, r2, r3, r4, r5, r6} !== 48'h0) begin miscompares++; $display("FAIL en_abort_regs got %h exp 0", {r1, r2, r3, r4, r5, r6}); end
        send_frame(48'hC0FFEE123456, 1'b0); idle(2 * DIV);
        vectors++; if ({r1, r2, r3, r4, r5, r6} !== 48'hC0FFEE123456) begin miscompares++; $display("FAIL en_after_regs got %h exp c0ffee123456", {r1, r2, r3, r4, r5, r6}); end
    endtask

    task automatic test_framing_error();
        int f0;
        do_reset();
        f0 = fv_cnt;
        send_byte(8'hA5, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b0);
        send_frame(48'hA1B2C3D4E5F6, 1'b0); idle(2 * DIV);
        vectors++; if (err !== 16'd1) begin miscompares++; $display("FAIL ferr_err got %0d exp 1", err); end
        vectors++; if (fv_cnt - f0 !== 1) begin miscompares++; $display("FAIL ferr_pulses got %0d exp 1", fv_cnt - f0); end
        vectors++; if ({r1, r2, r3, r4, r5, r6} !== 48'hA1B2C3D4E5F6) begin miscompares++; $display("FAIL ferr_regs got %h exp a1b2c3d4e5f6", {r1, r2, r3, r4, r5, r6}); end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
        idle(TO_CYC - 12 * DIV);
        send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        send_byte(8'h05, 1'b1); send_byte(8'h06, 1'b1); idle(2 * DIV);
        vectors++; if ({r1, r2, r3, r4, r5, r6} !== 48'h010203040506) begin miscompares++; $display("FAIL gap_ok_regs got %h exp 010203040506", {r1, r2, r3, r4, r5, r6}); end
        vectors++; if (err !== 16'd0) begin miscompares++; $display("FAIL gap_ok_err got %0d exp 0", err); end
        send_byte(8'hA5, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        idle(TO_CYC + 40);
        vectors++; if (err !== 16'd1) begin miscompares++; $display("FAIL timeout_err got %0d exp 1", err); end
        send_frame(48'h0A0B0C0D0E0F, 1'b0); idle(2 * DIV);
        vectors++; if ({r1, r2, r3, r4, r5, r6} !== 48'h0A0B0C0D0E0F) begin miscompares++; $display("FAIL timeout_regs got %h exp 0a0b0c0d0e0f", {r1, r2, r3, r4, r5, r6}); end
        vectors++; if (err !== 16'd1) begin miscompares++; $display("FAIL timeout_err_after got %0d exp 1", err); end
    endtask

    task automatic test_glitch_sync();
        int s0, f0;
        do_reset();
        s0 = stb_cnt; f0 = fv_cnt;
        rx = 1'b0; idle(HALF - 2); rx = 1'b1; idle(3 * DIV);
        vectors++; if (stb_cnt - s0 !== 0) begin miscompares++; $display("FAIL glitch_bytes got %0d exp 0", stb_cnt - s0); end
        vectors++; if (err !== 16'd0) begin miscompares++; $display("FAIL glitch_err got %0d exp 0", err); end
        send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1);
        send_frame(48'h5A5A00FF1234, 1'b0); idle(2 * DIV);
        vectors++; if (fv_cnt - f0 !== 1) begin miscompares++; $display("FAIL sync_pulses got %0d exp 1", fv_cnt - f0); end
        vectors++; if ({r1, r2, r3, r4, r5, r6} !== 48'h5A5A00FF1234) begin miscompares++; $display("FAIL sync_regs got %h exp 5a5a00ff1234", {r1, r2, r3, r4, r5, r6}); end
        vectors++; if (err !== 16'd0) begin miscompares++; $display("FAIL sync_err got %0d exp 0", err); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        send_frame(48'h111111111111, 1'b0); idle(DIV);
        send_byte(8'hA5, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        fork
            send_byte(8'h0F, 1'b1);
            begin idle(7 * DIV + HALF); res_n = 1'b0; idle(1); res_n = 1'b1; end
        join
        vectors++; if ({r1, r2, r3, r4, r5, r6} !== 48'h0) begin miscompares++; $display("FAIL rst_mid_regs got %h exp 0", {r1, r2, r3, r4, r5, r6}); end
        vectors++; if (led !== 1'b0) begin miscompares++; $display("FAIL rst_mid_led got %b exp 0", led); end
        vectors++; if (err !== 16'd0) begin miscompares++; $display("FAIL rst_mid_err got %0d exp 0", err); end
        idle(12 * DIV);
        send_frame(48'h987654321000, 1'b0); idle(2 * DIV);
        vectors++; if ({r1, r2, r3, r4, r5, r6} !== 48'h987654321000) begin miscompares++; $display("FAIL rst_next_regs got %h exp 987654321000", {r1, r2, r3, r4, r5, r6}); end
        vectors++; if (err !== 16'd0) begin miscompares++; $display("FAIL rst_next_err got %0d exp 0", err); end
    endtask

    task automatic test_back_to_back();
        int f0;
        do_reset();
        f0 = fv_cnt;
        send_frame(48'h010101010101, 1'b0);
        send_frame(48'hDEADBEEF0102, 1'b0); idle(2 * DIV);
        vectors++; if (fv_cnt - f0 !== 2) begin miscompares++; $display("FAIL b2b_pulses got %0d exp 2", fv_cnt - f0); end
        vectors++; if ({r1, r2, r3, r4, r5, r6} !== 48'hDEADBEEF0102) begin miscompares++; $display("FAIL b2b_regs got %h exp deadbeef0102", {r1, r2, r3, r4, r5, r6}); end
        vectors++; if (err !== 16'd0) begin miscompares++; $display("FAIL b2b_err got %0d exp 0", err); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_valid_frame();
`ifdef UART_REG_RX_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_rx_en_abort();
        test_framing_error();
        test_timeout();
        test_glitch_sync();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
